// File: rtl/stream_rr_merger_pkg.sv
// Shared definitions for stream_rr_merger: FSM state encoding, widths and a clog2 helper.
// The testbench imports this package too, so both sides agree on encodings.
package stream_rr_merger_pkg;

  localparam int DATA_W  = 32;
  localparam int GRANT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Ceiling log2; usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder: returns the first set request after ptr, wrapping modulo N.
// The search covers ptr+1 .. ptr+N, so ptr itself has the lowest priority.
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // NOTE: every output gets a default before the loop so no path leaves a latch.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IDX_W'((int'(ptr) + i) % N);
      if (!hit && req[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/stream_rr_merger.sv
// Round-robin merger of NUM_SRC FWFT word streams into one registered FWFT output stream.
// Define STREAM_RR_MERGER_TAG_EN to overwrite the top ID_WIDTH output bits with the source index.
module stream_rr_merger
  import stream_rr_merger_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int MAX_BURST = 16,
  parameter int ID_WIDTH  = 4
) (
  input  logic                      BUS_CLK,
  input  logic                      BUS_RST,
  input  logic [NUM_SRC-1:0]        SRC_EMPTY,
  input  logic [DATA_W*NUM_SRC-1:0] SRC_DATA,
  output logic [NUM_SRC-1:0]        SRC_READ,
  input  logic                      FIFO_READ_NEXT,
  output logic                      FIFO_EMPTY,
  output logic [DATA_W-1:0]         FIFO_DATA,
  output logic [GRANT_W-1:0]        GRANT_ID
);

  localparam int IDX_W = clog2(NUM_SRC);
  localparam int CNT_W = clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);

`ifdef STREAM_RR_MERGER_TAG_EN
  localparam int TAG_BITS = ID_WIDTH;
`else
  localparam int TAG_BITS = 0;
`endif
  // Bits of the source word that survive; the rest carry the tag.
  localparam logic [DATA_W-1:0] KEEP_MASK = {DATA_W{1'b1}} >> TAG_BITS;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;

  logic               pick_hit;
  logic [IDX_W-1:0]   pick_idx;
  logic               can_load;
  logic               grant_empty;
  logic               pop;
  logic [DATA_W-1:0]  src_word;
  logic [ID_WIDTH-1:0] tag;
  logic [DATA_W-1:0]  tag_word;
  logic [DATA_W-1:0]  load_word;

  rr_priority_pick #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (~SRC_EMPTY),
    .ptr (ptr_q),
    .hit (pick_hit),
    .idx (pick_idx)
  );

  assign grant_empty = SRC_EMPTY[grant_q];
  assign src_word    = SRC_DATA[DATA_W*grant_q +: DATA_W];
  assign tag         = ID_WIDTH'(grant_q);
  assign tag_word    = DATA_W'(tag) << (DATA_W - ID_WIDTH);
  assign load_word   = (src_word & KEEP_MASK) | (tag_word & ~KEEP_MASK);

  // The output register may be refilled in the same cycle it is drained.
  assign can_load = ~out_valid_q | FIFO_READ_NEXT;
  assign pop      = (state_q == HOLD) & ~grant_empty & can_load & ~BUS_RST;

  always_comb begin
    SRC_READ = '0;
    if (pop) begin
      SRC_READ[grant_q] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_hit) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (grant_empty) begin
          state_d = IDLE;
          ptr_d   = grant_q;
        end else if (pop) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == BURST_LAST) begin
            state_d = IDLE;
            ptr_d   = grant_q;
          end
        end
      end
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = load_word;
    end else if (FIFO_READ_NEXT) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments only; reset is synchronous and clears the held word.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q     <= IDLE;
      ptr_q       <= IDX_W'(NUM_SRC - 1);
      grant_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign FIFO_EMPTY = ~out_valid_q;
  assign FIFO_DATA  = out_data_q;
  assign GRANT_ID   = GRANT_W'(grant_q);

endmodule

// File: tb/tb_stream_rr_merger.sv
// Randomised scoreboard bench for stream_rr_merger; a burst-level arbitration model predicts the word order.
`timescale 1ns/1ps
module tb_stream_rr_merger;
  import stream_rr_merger_pkg::*;

  localparam int NUM_SRC   = 4;
  localparam int MAX_BURST = 16;
  localparam int ID_WIDTH  = 4;

  logic                      BUS_CLK = 1'b0;
  logic                      BUS_RST;
  logic [NUM_SRC-1:0]        SRC_EMPTY;
  logic [DATA_W*NUM_SRC-1:0] SRC_DATA;
  logic [NUM_SRC-1:0]        SRC_READ;
  logic                      FIFO_READ_NEXT;
  logic                      FIFO_EMPTY;
  logic [DATA_W-1:0]         FIFO_DATA;
  logic [GRANT_W-1:0]        GRANT_ID;

  stream_rr_merger #(
    .NUM_SRC   (NUM_SRC),
    .MAX_BURST (MAX_BURST),
    .ID_WIDTH  (ID_WIDTH)
  ) dut (
    .BUS_CLK        (BUS_CLK),
    .BUS_RST        (BUS_RST),
    .SRC_EMPTY      (SRC_EMPTY),
    .SRC_DATA       (SRC_DATA),
    .SRC_READ       (SRC_READ),
    .FIFO_READ_NEXT (FIFO_READ_NEXT),
    .FIFO_EMPTY     (FIFO_EMPTY),
    .FIFO_DATA      (FIFO_DATA),
    .GRANT_ID       (GRANT_ID)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  logic [31:0] src_q[NUM_SRC][$];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          m_ptr;
  int          rd_prob = 100;
  bit          stall_force = 1'b0;
  logic [NUM_SRC-1:0] rd_mask;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expect_word(input int src, input logic [31:0] w);
    logic [31:0] r;
    r = w;
`ifdef STREAM_RR_MERGER_TAG_EN
    r[31 -: ID_WIDTH] = ID_WIDTH'(src);
`endif
    return r;
  endfunction

  function automatic bit src_pending();
    bit any;
    any = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) if (src_q[i].size() != 0) any = 1'b1;
    return any;
  endfunction

  task automatic update_src();
    for (int i = 0; i < NUM_SRC; i++) begin
      SRC_EMPTY[i] = (src_q[i].size() == 0);
      SRC_DATA[32*i +: 32] = (src_q[i].size() == 0) ? 32'h0 : src_q[i][0];
    end
  endtask

  task automatic load(input int src, input int n);
    for (int j = 0; j < n; j++) src_q[src].push_back($urandom);
  endtask

  // Whole-burst model: next non-empty source after the pointer gets min(MAX_BURST, remaining) words.
  task automatic model_schedule();
    int len[NUM_SRC];
    int pos[NUM_SRC];
    int g;
    int n;
    for (int i = 0; i < NUM_SRC; i++) begin
      len[i] = src_q[i].size();
      pos[i] = 0;
    end
    while (1) begin
      g = -1;
      for (int k = 1; k <= NUM_SRC; k++) begin
        if (g < 0 && pos[(m_ptr + k) % NUM_SRC] < len[(m_ptr + k) % NUM_SRC]) g = (m_ptr + k) % NUM_SRC;
      end
      if (g < 0) break;
      n = len[g] - pos[g];
      if (n > MAX_BURST) n = MAX_BURST;
      for (int j = 0; j < n; j++) exp_q.push_back(expect_word(g, src_q[g][pos[g] + j]));
      pos[g] += n;
      m_ptr = g;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int cyc;
    bit done;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < budget) begin
      @(negedge BUS_CLK);
      cyc++;
      done = (exp_q.size() == 0) && !src_pending() && FIFO_EMPTY;
    end
    check({name, "_drained"}, 32'(done), 32'd1);
    exp_q.delete();
    repeat (3) @(negedge BUS_CLK);
  endtask

  // Source and sink model: pop what the DUT strobed, then present the next heads.
  initial begin
    forever begin
      @(posedge BUS_CLK);
      rd_mask = SRC_READ;
      #1;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (rd_mask[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      end
      update_src();
      FIFO_READ_NEXT = stall_force ? 1'b0 : ($urandom_range(99) < rd_prob);
    end
  end

  // Monitor: every consumed output word is compared against the scoreboard head.
  always @(negedge BUS_CLK) begin
    if (!BUS_RST) begin
      check("read_onehot", 32'($onehot0(SRC_READ)), 32'd1);
      check("read_nonempty_only", 32'(SRC_READ & SRC_EMPTY), 32'd0);
      if (!FIFO_EMPTY && FIFO_READ_NEXT) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%08h expected no word at %0t", FIFO_DATA, $time);
        end else begin
          check("out_word", FIFO_DATA, exp_q.pop_front());
        end
      end
    end
  end

  logic [31:0] tag_exp;
  bit          seen;

  initial begin
    BUS_RST        = 1'b1;
    SRC_EMPTY      = '1;
    SRC_DATA       = '0;
    FIFO_READ_NEXT = 1'b0;
    m_ptr          = NUM_SRC - 1;
    repeat (3) @(negedge BUS_CLK);
    check("rst_empty", 32'(FIFO_EMPTY), 32'd1);
    check("rst_data", FIFO_DATA, 32'd0);
    check("rst_read", 32'(SRC_READ), 32'd0);
    check("rst_grant", 32'(GRANT_ID), 32'd0);
    BUS_RST = 1'b0;
    repeat (2) @(negedge BUS_CLK);

    // Single source, three words, downstream always reading.
    rd_prob = 100;
    load(0, 3);
    model_schedule();
    update_src();
    #1;
    check("single_bubble", 32'(SRC_READ[0]), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge BUS_CLK);
      check($sformatf("single_read_%0d", k), 32'(SRC_READ[0]), 32'(k <= 3));
    end
    check("single_empty_after", 32'(FIFO_EMPTY), 32'd1);
    drain("single", 50);

    // All sources busy: full-length bursts in round-robin order.
    for (int i = 0; i < NUM_SRC; i++) load(i, 40);
    model_schedule();
    update_src();
    drain("all_busy", 1000);

    // Downstream stall with a word pending mid-burst.
    load(1, 20);
    load(3, 20);
    model_schedule();
    update_src();
    repeat (6) @(negedge BUS_CLK);
    stall_force = 1'b1;
    repeat (2) @(negedge BUS_CLK);
    for (int k = 0; k < 10; k++) begin
      check("stall_read", 32'(SRC_READ), 32'd0);
      check("stall_valid", 32'(FIFO_EMPTY), 32'd0);
      check("stall_data", FIFO_DATA, (exp_q.size() != 0) ? exp_q[0] : 32'hDEAD_BEEF);
      @(negedge BUS_CLK);
    end
    stall_force = 1'b0;
    drain("stall", 500);

    // Short source bursts: early exit on empty, next grant moves on or wraps.
    load(2, 5);
    load(3, 6);
    load(0, 4);
    model_schedule();
    update_src();
    drain("short_a", 300);
    load(2, 5);
    load(0, 3);
    model_schedule();
    update_src();
    drain("short_b", 300);

    // Random lengths and random downstream throttling.
    for (int it = 0; it < 6; it++) begin
      rd_prob = $urandom_range(100, 20);
      for (int i = 0; i < NUM_SRC; i++) load(i, $urandom_range(40, 0));
      model_schedule();
      update_src();
      drain($sformatf("random_%0d", it), 3000);
    end
    rd_prob = 100;

    // Reset while holding a word in HOLD; the held word is discarded.
    stall_force = 1'b1;
    load(1, 20);
    load(2, 20);
    update_src();
    repeat (4) @(negedge BUS_CLK);
    check("pre_rst_valid", 32'(FIFO_EMPTY), 32'd0);
    #2;
    BUS_RST        = 1'b1;
    FIFO_READ_NEXT = 1'b1;
    #1;
    check("rst_cycle_read", 32'(SRC_READ), 32'd0);
    @(negedge BUS_CLK);
    BUS_RST = 1'b0;
    check("mid_rst_empty", 32'(FIFO_EMPTY), 32'd1);
    check("mid_rst_data", FIFO_DATA, 32'd0);
    check("mid_rst_grant", 32'(GRANT_ID), 32'd0);
    for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
    exp_q.delete();
    m_ptr = NUM_SRC - 1;
    for (int i = 0; i < NUM_SRC; i++) load(i, 3);
    model_schedule();
    update_src();
    stall_force = 1'b0;
    drain("after_rst", 300);

    // Tag handling on an all-ones word from source 3.
`ifdef STREAM_RR_MERGER_TAG_EN
    tag_exp = 32'h3FFF_FFFF;
`else
    tag_exp = 32'hFFFF_FFFF;
`endif
    src_q[3].push_back(32'hFFFF_FFFF);
    model_schedule();
    update_src();
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge BUS_CLK);
      if (!FIFO_EMPTY) begin
        seen = 1'b1;
        check("tag_word", FIFO_DATA, tag_exp);
      end
    end
    check("tag_word_seen", 32'(seen), 32'd1);
    drain("tag", 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
